touch_sample_controller: RTL

Sequences the AD7843 touchscreen driver for the digit-capture path. Schedules conversions at a fixed rate, collects a batch of 2^AVG_LOG2 raw X/Y samples per tick and rejects jittery batches. Averages and scales each accepted batch to LT24 pixel coordinates, then hands points to the stroke rasteriser over a valid/ready interface. Also tracks pen-down state and flags the end of each stroke.

---
 rtl/touch_sample_controller_pkg.sv | 26 ++
 rtl/touch_sample_controller_coord_scaler.sv | 46 ++++
 rtl/touch_sample_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/touch_sample_controller_pkg.sv
// Shared definitions for the touchscreen sample controller: FSM states,
// LT24 screen limits, coordinate widths and the Q0.12 scaling shift.
package touch_sample_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ACQ   = 3'd2,
    ST_CHECK = 3'd3,
    ST_SCALE = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  localparam int RAW_W      = 12;
  localparam int X_W        = 8;
  localparam int Y_W        = 9;
  localparam int X_MAX      = 239;
  localparam int Y_MAX      = 319;
  localparam int GAIN_SHIFT = 12;

  function automatic logic [RAW_W-1:0] abs_diff(input logic [RAW_W-1:0] a,
                                                input logic [RAW_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/touch_sample_controller_coord_scaler.sv
// One-axis raw-to-pixel converter: offset/clamp, Q0.12 gain, saturate.
// Two-cycle latency, fully pipelined.
module touch_coord_scaler
  import touch_sample_controller_pkg::*;
#(
  parameter int RAW_MIN = 200,
  parameter int GAIN    = 266,
  parameter int MAX     = 239,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [RAW_W-1:0] i_raw,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_pix
);

  localparam int PROD_W = RAW_W + GAIN_SHIFT;
  localparam logic [RAW_W-1:0]  MIN_L  = RAW_W'(RAW_MIN);
  localparam logic [PROD_W-1:0] GAIN_L = PROD_W'(GAIN);
  localparam logic [PROD_W-1:0] MAX_L  = PROD_W'(MAX);

  logic             r_v1;
  logic [RAW_W-1:0] r_d;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_scaled;

  assign w_prod   = PROD_W'(r_d) * GAIN_L;
  assign w_scaled = w_prod >> GAIN_SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_d     <= '0;
      o_valid <= 1'b0;
      o_pix   <= '0;
    end else begin
      r_v1    <= i_valid;
      r_d     <= (i_raw > MIN_L) ? (i_raw - MIN_L) : '0;
      o_valid <= r_v1;
      o_pix   <= (w_scaled > MAX_L) ? OUT_W'(MAX) : w_scaled[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/touch_sample_controller.sv
// Periodic AD7843 batch sampler with jitter rejection, averaging, pixel
// scaling, valid/ready point output and pen-down / stroke-end tracking.
module touch_sample_controller
  import touch_sample_controller_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 20000,
  parameter int AVG_LOG2      = 2,
  parameter int JITTER_MAX    = 64,
  parameter int CONV_TIMEOUT  = 128,
  parameter int X_RAW_MIN     = 200,
  parameter int X_GAIN        = 266,
  parameter int Y_RAW_MIN     = 200,
  parameter int Y_GAIN        = 354
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             adc_penirq_n,
  output logic             drv_en,
  input  logic             drv_pos_ready,
  input  logic [RAW_W-1:0] drv_x_pos,
  input  logic [RAW_W-1:0] drv_y_pos,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic [X_W-1:0]   pt_x,
  output logic [Y_W-1:0]   pt_y,
  output logic             pen_down,
  output logic             stroke_end
);

  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int SUM_W = RAW_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TMO_W = $clog2(CONV_TIMEOUT + 1);

  state_t           r_state;
  logic             r_pen_meta;
  logic             r_pen_sync;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum_x;
  logic [SUM_W-1:0] r_sum_y;
  logic [RAW_W-1:0] r_ref_x;
  logic [RAW_W-1:0] r_ref_y;
  logic             r_reject;
  logic             r_abort;
  logic [TMO_W-1:0] r_tmo;

  logic             w_tick;
  logic             w_last;
  logic             w_tmo_hit;
  logic             w_jitter;
  logic             w_drop;
  logic [RAW_W-1:0] w_avg_x;
  logic [RAW_W-1:0] w_avg_y;
  logic             w_scale_start;
  logic             w_vx;
  logic             w_vy;
  logic [X_W-1:0]   w_pix_x;
  logic [Y_W-1:0]   w_pix_y;

  // penirq is asynchronous to clk; after reset it reads as "pen up"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pen_meta <= 1'b1;
      r_pen_sync <= 1'b1;
    end else begin
      r_pen_meta <= adc_penirq_n;
      r_pen_sync <= r_pen_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (!enable || r_timer == TMR_W'(SAMPLE_PERIOD - 1)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign w_tick    = enable && (r_timer == TMR_W'(SAMPLE_PERIOD - 1));
  assign w_last    = (r_cnt == CNT_W'(NSAMP - 1));
  assign w_tmo_hit = (r_tmo == TMO_W'(CONV_TIMEOUT - 1));
  assign w_drop    = r_abort || !enable;
  assign w_jitter  = (abs_diff(drv_x_pos, r_ref_x) > RAW_W'(JITTER_MAX)) ||
                     (abs_diff(drv_y_pos, r_ref_y) > RAW_W'(JITTER_MAX));

  assign w_avg_x       = r_sum_x[SUM_W-1 -: RAW_W];
  assign w_avg_y       = r_sum_y[SUM_W-1 -: RAW_W];
  assign w_scale_start = (r_state == ST_CHECK) && !r_reject;

  touch_coord_scaler #(
    .RAW_MIN(X_RAW_MIN), .GAIN(X_GAIN), .MAX(X_MAX), .OUT_W(X_W)
  ) u_scale_x (
    .clk(clk), .reset_n(reset_n), .i_valid(w_scale_start), .i_raw(w_avg_x),
    .o_valid(w_vx), .o_pix(w_pix_x)
  );

  touch_coord_scaler #(
    .RAW_MIN(Y_RAW_MIN), .GAIN(Y_GAIN), .MAX(Y_MAX), .OUT_W(Y_W)
  ) u_scale_y (
    .clk(clk), .reset_n(reset_n), .i_valid(w_scale_start), .i_raw(w_avg_y),
    .o_valid(w_vy), .o_pix(w_pix_y)
  );

  // Pen lift on disable is handled in IDLE so it can never collide with an accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sum_x    <= '0;
      r_sum_y    <= '0;
      r_ref_x    <= '0;
      r_ref_y    <= '0;
      r_reject   <= 1'b0;
      r_abort    <= 1'b0;
      r_tmo      <= '0;
      drv_en     <= 1'b0;
      pt_valid   <= 1'b0;
      pt_x       <= '0;
      pt_y       <= '0;
      pen_down   <= 1'b0;
      stroke_end <= 1'b0;
    end else begin
      stroke_end <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          drv_en   <= 1'b0;
          pt_valid <= 1'b0;
          if (pen_down) begin
            pen_down   <= 1'b0;
            stroke_end <= 1'b1;
          end
          if (enable) r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (!r_pen_sync) begin
              r_state  <= ST_ACQ;
              r_cnt    <= '0;
              r_sum_x  <= '0;
              r_sum_y  <= '0;
              r_reject <= 1'b0;
              r_abort  <= 1'b0;
              r_tmo    <= '0;
              drv_en   <= 1'b1;
            end else if (pen_down) begin
              pen_down   <= 1'b0;
              stroke_end <= 1'b1;
            end
          end
        end

        ST_ACQ: begin
          if (!enable) r_abort <= 1'b1;
          // A strobe wins over a simultaneous timeout
          if (drv_pos_ready) begin
            r_tmo   <= '0;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_sum_x <= r_sum_x + SUM_W'(drv_x_pos);
            r_sum_y <= r_sum_y + SUM_W'(drv_y_pos);
            if (r_cnt == '0) begin
              r_ref_x <= drv_x_pos;
              r_ref_y <= drv_y_pos;
            end else if (w_jitter) begin
              r_reject <= 1'b1;
            end
            if (w_drop) begin
              drv_en  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (w_last) begin
              drv_en  <= 1'b0;
              r_state <= ST_CHECK;
            end
          end else if (w_tmo_hit) begin
            drv_en  <= 1'b0;
            r_state <= w_drop ? ST_IDLE : ST_WAIT;
            if (pen_down) begin
              pen_down   <= 1'b0;
              stroke_end <= 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        ST_CHECK: begin
          r_state <= r_reject ? ST_WAIT : ST_SCALE;
        end

        ST_SCALE: begin
          if (w_vx && w_vy) begin
            pt_x     <= w_pix_x;
            pt_y     <= w_pix_y;
            pt_valid <= 1'b1;
            r_state  <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            pen_down <= 1'b1;
            r_state  <= enable ? ST_WAIT : ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
